// File: rtl/phy_pkg.sv
// Shared PHY definitions: link alignment symbol, default lock threshold and
// the receive state encoding used by both the transmit and receive paths.
package phy_pkg;

    localparam logic [7:0] COM_CHAR_DEFAULT      = 8'hBC;
    localparam int         COM_THRESHOLD_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_ACTIVE = 2'd2
    } phy_state_e;

endpackage

// File: rtl/rx_byte_aligner.sv
// Serial-to-byte front end: shifts bits in MSB first, hunts for the COM symbol
// bit by bit and then confirms it on byte boundaries until lock is declared.
module rx_byte_aligner
    import phy_pkg::*;
#(
    parameter logic [7:0] COM_CHAR      = COM_CHAR_DEFAULT,
    parameter int         COM_THRESHOLD = COM_THRESHOLD_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    input  phy_state_e state,
    output logic [7:0] rx_byte,
    output logic       rx_is_com,
    output logic       byte_stb,
    output logic       lock_done
);

    localparam int            CW    = $clog2(COM_THRESHOLD + 1);
    localparam logic [CW-1:0] TH_M1 = CW'(COM_THRESHOLD - 1);

    logic [7:0]    shift_q;
    logic [2:0]    bit_cnt_q;
    logic [CW-1:0] com_count_q;
    logic          boundary;
    logic          in_init;
    logic          searching;

    // bit_cnt_q == 7 means shift_q holds a complete byte on the locked grid
    assign boundary  = (bit_cnt_q == 3'd7);
    assign in_init   = (state == ST_INIT);
    assign searching = in_init && (com_count_q == '0);

    assign rx_byte   = shift_q;
    assign rx_is_com = (shift_q == COM_CHAR);
    assign byte_stb  = (state == ST_ACTIVE) && boundary;
    assign lock_done = in_init && rx_is_com &&
                       (searching ? (COM_THRESHOLD <= 1)
                                  : (boundary && (com_count_q == TH_M1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            com_count_q <= '0;
        end else begin
            shift_q   <= {shift_q[6:0], serial_in};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (searching) begin
                // first COM found anywhere: pin the byte grid to it
                if (rx_is_com) begin
                    com_count_q <= CW'(1);
                    bit_cnt_q   <= '0;
                end
            end else if (in_init && boundary) begin
                com_count_q <= rx_is_com ? com_count_q + CW'(1) : '0;
            end
        end
    end

endmodule

// File: rtl/serial_rx_aligner.sv
// Serial receive aligner top: lock FSM plus assembly of four data bytes into
// a 32-bit word, with idle COMs skipped and mid-word COMs flagged as errors.
module serial_rx_aligner
    import phy_pkg::*;
#(
    parameter logic [7:0] COM_CHAR      = COM_CHAR_DEFAULT,
    parameter int         COM_THRESHOLD = COM_THRESHOLD_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        serial_in,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        active,
    output logic        err_out
);

    phy_state_e  state_q;
    phy_state_e  state_d;
    logic [7:0]  rx_byte;
    logic        rx_is_com;
    logic        byte_stb;
    logic        lock_done;
    logic [1:0]  byte_cnt_q;
    logic [23:0] word_q;

    rx_byte_aligner #(
        .COM_CHAR      (COM_CHAR),
        .COM_THRESHOLD (COM_THRESHOLD)
    ) u_aligner (
        .clk       (clk),
        .reset     (reset),
        .serial_in (serial_in),
        .state     (state_q),
        .rx_byte   (rx_byte),
        .rx_is_com (rx_is_com),
        .byte_stb  (byte_stb),
        .lock_done (lock_done)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_RESET;
        else       state_q <= state_d;
    end

    // ACTIVE is sticky; only reset returns the link to the search
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   if (lock_done) state_d = ST_ACTIVE;
            ST_ACTIVE: state_d = ST_ACTIVE;
            default:   state_d = ST_RESET;
        endcase
    end

    assign active = (state_q == ST_ACTIVE);

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt_q <= '0;
            data_out   <= '0;
            valid_out  <= 1'b0;
            err_out    <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            err_out   <= 1'b0;
            if (byte_stb) begin
                if (rx_is_com) begin
                    // COM at a word start is idle fill; anywhere else it truncates the word
                    if (byte_cnt_q != 2'd0) begin
                        err_out    <= 1'b1;
                        byte_cnt_q <= '0;
                    end
                end else begin
                    byte_cnt_q <= byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        data_out  <= {word_q, rx_byte};
                        valid_out <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (byte_stb && !rx_is_com) begin
            case (byte_cnt_q)
                2'd0:    word_q[23:16] <= rx_byte;
                2'd1:    word_q[15:8]  <= rx_byte;
                2'd2:    word_q[7:0]   <= rx_byte;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/serial_rx_aligner.md
SERIAL_RX_ALIGNER -- requirements
Module: serial_rx_aligner

Interface
REQ-001 The block SHALL have parameter COM_CHAR, default 8'hBC, the alignment/idle symbol.
REQ-002 The block SHALL have parameter COM_THRESHOLD, default 4, the consecutive aligned COM count needed to leave INIT.
REQ-003 The block SHALL have port clk  input  1  the single clock, one serial bit per rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port serial_in  input  1  serial lane from the upstream transmitter, MSB of each byte first.
REQ-006 The block SHALL have port data_out  output  32  received word, first byte in [31:24].
REQ-007 The block SHALL have port valid_out  output  1  one-cycle strobe qualifying data_out.
REQ-008 The block SHALL have port active  output  1  high while the state is ACTIVE.
REQ-009 The block SHALL have port err_out  output  1  one-cycle strobe on a discarded partial word.

Function
REQ-010 The block SHALL shift serial_in into an 8-bit register every clk, newest bit in [0].
REQ-011 The block SHALL implement states RESET, INIT and ACTIVE.
REQ-012 RESET SHALL be held while reset=1 and SHALL go to INIT on the first clk with reset=0.
REQ-013 In INIT with com_count=0, the block SHALL compare the shift register to COM_CHAR every clk; on a match it SHALL set com_count=1 and zero the 3-bit bit counter (byte boundary locked).
REQ-014 In INIT with com_count>0, the block SHALL compare only at byte boundaries (bit counter wrap 7->0).
REQ-015 A boundary COM in INIT SHALL increment com_count; on reaching COM_THRESHOLD the state SHALL become ACTIVE on the next clk.
REQ-016 A boundary non-COM byte in INIT SHALL clear com_count and resume bit-wise search.
REQ-017 In ACTIVE, each boundary byte that is not COM_CHAR SHALL be stored in slot byte_cnt (0..3, MSB-first) and byte_cnt incremented.
REQ-018 When the fourth byte is stored, data_out SHALL update and valid_out SHALL pulse for exactly one clk on the clk after the edge sampling that byte's last bit; byte_cnt SHALL wrap to 0.
REQ-019 A COM byte in ACTIVE with byte_cnt=0 SHALL be treated as idle: no output change.
REQ-020 A COM byte in ACTIVE with byte_cnt!=0 SHALL discard the partial word, clear byte_cnt and pulse err_out for one clk.
REQ-021 Data bytes equal to COM_CHAR SHALL NOT be transportable; this is a link-level rule.
REQ-022 data_out SHALL hold its last value between valid_out pulses.
REQ-023 ACTIVE SHALL be left only by reset.

Reset
REQ-024 On a clk with reset=1, the block SHALL set data_out=0, valid_out=0, err_out=0, active=0, shift register=0, com_count=0, byte_cnt=0, bit counter=0, state=RESET.
REQ-025 Reset asserted mid-word or mid-alignment SHALL discard all partial state without a valid_out or err_out pulse.

Structure
REQ-026 COM_CHAR, COM_THRESHOLD default and the state encoding SHALL live in the shared phy package used by phy_tx.
REQ-027 The byte aligner (shift register, bit counter, INIT search) SHALL be sub-module rx_byte_aligner; word assembly and output SHALL remain in the top.

Verification
REQ-028 Reset for 2 clks, then 4 aligned BC bytes -> active=1 within 1 clk after the 32nd bit; valid_out=0 throughout.
REQ-029 Active, serial bytes F4 FF EF 7F -> one valid_out pulse with data_out=32'hF4FFEF7F, err_out=0.
REQ-030 3 random bits, then BC x4, then E8 EE E4 EE -> alignment despite offset; data_out=32'hE8EEE4EE.
REQ-031 BC BC BC 55 BC BC BC BC -> com_count cleared at 55; active rises only after the second group of 4 BCs.
REQ-032 Active, bytes D4 DD BC -> err_out one-clk pulse, no valid_out; following 8C CC 1C CC -> data_out=32'h8CCC1CCC.
REQ-033 Reset asserted after 2 data bytes in ACTIVE -> all outputs 0, active=0 next clk; re-alignment required before any valid_out.
